// File: rtl/rab_inval_sequencer_pkg.sv
// Shared types and default sizing for the RAB invalidation sequencer.
package rab_inval_pkg;

    localparam int AW_DEF               = 32;
    localparam int N_SLICES_DEF         = 32;
    localparam int L2_N_SETS_DEF        = 32;
    localparam int L2_N_SET_ENTRIES_DEF = 32;
    localparam int PAGE_BITS_DEF        = 12;
    localparam int L2_N_DEF             = L2_N_SETS_DEF * L2_N_SET_ENTRIES_DEF;
    localparam int VPN_W_DEF            = AW_DEF - PAGE_BITS_DEF;

    // Index width for a table of n entries; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int L2_IDX_W_DEF = idx_width(L2_N_DEF);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_L1_SCAN = 3'd1,
        ST_L2_RD   = 3'd2,
        ST_L2_CHK  = 3'd3,
        ST_DONE    = 3'd4
    } rab_inval_state_e;

    // One L2 TLB RAM word as seen on l2_rdata_i / l2_wdata_o.
    typedef struct packed {
        logic [VPN_W_DEF-1:0] vpn;
        logic                 valid;
    } rab_l2_entry_t;

endpackage

// File: rtl/rab_inval_sequencer_if.sv
// Invalidation request handshake between the config register file and the sequencer.
interface rab_inval_sequencer_if
    import rab_inval_pkg::*;
#(
    parameter int AW = AW_DEF
);
    logic          inval_valid;
    logic          inval_ready;
    logic [AW-1:0] inval_start;
    logic [AW-1:0] inval_end;

    modport master (
        output inval_valid,
        output inval_start,
        output inval_end,
        input  inval_ready
    );

    modport slave (
        input  inval_valid,
        input  inval_start,
        input  inval_end,
        output inval_ready
    );
endinterface

// File: rtl/rab_inval_sequencer_range_cmp.sv
// Inclusive range overlap: [a_lo, a_hi] intersects [b_lo, b_hi], unsigned, no wrap.
module rab_inval_range_cmp
    import rab_inval_pkg::*;
#(
    parameter int W = AW_DEF
) (
    input  logic         en_i,
    input  logic [W-1:0] a_lo_i,
    input  logic [W-1:0] a_hi_i,
    input  logic [W-1:0] b_lo_i,
    input  logic [W-1:0] b_hi_i,
    output logic         hit_o
);

    // Pure overlap test; the caller folds entry-valid and empty-request into en_i.
    assign hit_o = en_i && (a_lo_i <= b_hi_i) && (a_hi_i >= b_lo_i);

endmodule

// File: rtl/rab_inval_sequencer.sv
// Walks all L1 slices then all L2 TLB entries, clearing every entry that overlaps
// the latched invalidation range, while holding the config lock.
module rab_inval_sequencer
    import rab_inval_pkg::*;
#(
    parameter int AW               = AW_DEF,
    parameter int N_SLICES         = N_SLICES_DEF,
    parameter int L2_N_SETS        = L2_N_SETS_DEF,
    parameter int L2_N_SET_ENTRIES = L2_N_SET_ENTRIES_DEF,
    parameter int PAGE_BITS        = PAGE_BITS_DEF
) (
    input  logic                                                clk_i,
    input  logic                                                rst_ni,
    rab_inval_sequencer_if.slave                                req_if,
    input  logic [N_SLICES-1:0][AW-1:0]                         l1_start_i,
    input  logic [N_SLICES-1:0][AW-1:0]                         l1_end_i,
    input  logic [N_SLICES-1:0]                                 l1_valid_i,
    output logic [N_SLICES-1:0]                                 l1_clr_o,
    output logic                                                l2_req_o,
    output logic                                                l2_we_o,
    output logic [idx_width(L2_N_SETS*L2_N_SET_ENTRIES)-1:0]    l2_addr_o,
    output logic [AW-PAGE_BITS:0]                               l2_wdata_o,
    input  logic [AW-PAGE_BITS:0]                               l2_rdata_i,
    output logic                                                cfg_lock_o,
    output logic                                                busy_o,
    output logic                                                inval_done_o,
    output logic [15:0]                                         inval_cnt_o
);

    localparam int L2_N  = L2_N_SETS * L2_N_SET_ENTRIES;
    localparam int VPN_W = AW - PAGE_BITS;
    localparam int L1_W  = idx_width(N_SLICES);
    localparam int L2_W  = idx_width(L2_N);
    localparam int IDX_W = (L1_W > L2_W) ? L1_W : L2_W;

    localparam logic [IDX_W-1:0] L1_LAST = IDX_W'(N_SLICES - 1);
    localparam logic [IDX_W-1:0] L2_LAST = IDX_W'(L2_N - 1);

    rab_inval_state_e state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [AW-1:0]    start_q, start_d;
    logic [AW-1:0]    end_q, end_d;

    logic             req_empty;
    logic [L1_W-1:0]  l1_sel;
    logic             l1_hit;
    logic             l1_clr_en;
    logic [VPN_W-1:0] rd_vpn;
    logic             rd_valid;
    logic             l2_hit;

    // The cleared-entry counter sticks at all-ones instead of wrapping.
    function automatic logic [15:0] cnt_sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // start > end is an empty range: it must never hit, even where the
    // page-shifted bounds happen to coincide.
    assign req_empty = (start_q > end_q);
    assign l1_sel    = idx_q[L1_W-1:0];
    assign rd_vpn    = l2_rdata_i[VPN_W:1];
    assign rd_valid  = l2_rdata_i[0];

    rab_inval_range_cmp #(.W(AW)) u_l1_cmp (
        .en_i   (l1_valid_i[l1_sel] && !req_empty),
        .a_lo_i (l1_start_i[l1_sel]),
        .a_hi_i (l1_end_i[l1_sel]),
        .b_lo_i (start_q),
        .b_hi_i (end_q),
        .hit_o  (l1_hit)
    );

    // An L2 entry covers exactly one page, so its range is [vpn, vpn].
    rab_inval_range_cmp #(.W(AW)) u_l2_cmp (
        .en_i   (rd_valid && !req_empty),
        .a_lo_i ({{PAGE_BITS{1'b0}}, rd_vpn}),
        .a_hi_i ({{PAGE_BITS{1'b0}}, rd_vpn}),
        .b_lo_i (start_q >> PAGE_BITS),
        .b_hi_i (end_q >> PAGE_BITS),
        .hit_o  (l2_hit)
    );

    // One-hot slice clear: only the slice currently indexed can pulse.
    generate
        for (genvar gi = 0; gi < N_SLICES; gi++) begin : g_l1_clr
            assign l1_clr_o[gi] = l1_clr_en && (l1_sel == L1_W'(gi));
        end
    endgenerate

    // Status outputs are pure decodes of the registered state.
    assign req_if.inval_ready = (state_q == ST_IDLE);
    assign busy_o             = (state_q != ST_IDLE);
    assign cfg_lock_o         = busy_o;
    assign inval_done_o       = (state_q == ST_DONE);
    assign inval_cnt_o        = cnt_q;

    // State, walk index, counter and latched range.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            start_q <= '0;
            end_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            end_q   <= end_d;
        end
    end

    // Next-state and per-state L1/L2 access generation.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        start_d    = start_q;
        end_d      = end_q;
        l1_clr_en  = 1'b0;
        l2_req_o   = 1'b0;
        l2_we_o    = 1'b0;
        l2_addr_o  = '0;
        l2_wdata_o = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_if.inval_valid) begin
                    start_d = req_if.inval_start;
                    end_d   = req_if.inval_end;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_L1_SCAN;
                end
            end
            ST_L1_SCAN: begin
                if (l1_hit) begin
                    l1_clr_en = 1'b1;
                    cnt_d     = cnt_sat_inc(cnt_q);
                end
                if (idx_q == L1_LAST) begin
                    idx_d   = '0;
                    state_d = ST_L2_RD;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_L2_RD: begin
                l2_req_o  = 1'b1;
                l2_addr_o = idx_q[L2_W-1:0];
                state_d   = ST_L2_CHK;
            end
            ST_L2_CHK: begin
                // Read data from the L2_RD cycle is valid now; write back with valid cleared.
                if (l2_hit) begin
                    l2_req_o   = 1'b1;
                    l2_we_o    = 1'b1;
                    l2_addr_o  = idx_q[L2_W-1:0];
                    l2_wdata_o = {rd_vpn, 1'b0};
                    cnt_d      = cnt_sat_inc(cnt_q);
                end
                if (idx_q == L2_LAST) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_L2_RD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rab_inval_sequencer.sv
// Self-checking bench: random and directed invalidations against a range-rule model.
module tb_rab_inval_sequencer;
    import rab_inval_pkg::*;

    localparam int AW  = 32;
    localparam int NS  = 32;
    localparam int L2N = 1024;
    localparam int PB  = 12;
    localparam int VW  = AW - PB;
    localparam int DW  = VW + 1;
    localparam int LAT = NS + 2 * L2N + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rab_inval_sequencer_if #(.AW(AW)) req_if ();

    logic [NS-1:0][AW-1:0] l1_s, l1_e;
    logic [NS-1:0]         l1_v, l1_clr;
    logic                  l2_req, l2_we;
    logic [9:0]            l2_addr;
    logic [DW-1:0]         l2_wdata, l2_rdata;
    logic                  lock, busy, done;
    logic [15:0]           cnt;

    rab_inval_sequencer dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_if       (req_if),
        .l1_start_i   (l1_s),
        .l1_end_i     (l1_e),
        .l1_valid_i   (l1_v),
        .l1_clr_o     (l1_clr),
        .l2_req_o     (l2_req),
        .l2_we_o      (l2_we),
        .l2_addr_o    (l2_addr),
        .l2_wdata_o   (l2_wdata),
        .l2_rdata_i   (l2_rdata),
        .cfg_lock_o   (lock),
        .busy_o       (busy),
        .inval_done_o (done),
        .inval_cnt_o  (cnt)
    );

    // Stand-in for the slice prot-bit flops: bulk load or clear on pulse.
    logic          l1_ld = 1'b0;
    logic [NS-1:0] l1_ld_val;
    always @(posedge clk) begin
        if (l1_ld) l1_v <= l1_ld_val;
        else       l1_v <= l1_v & ~l1_clr;
    end

    // Stand-in for the L2 TLB RAM: one-cycle read latency, bulk load from an image.
    rab_l2_entry_t ram     [L2N];
    rab_l2_entry_t ram_img [L2N];
    logic          ram_ld = 1'b0;
    always @(posedge clk) begin
        if (ram_ld) for (int k = 0; k < L2N; k++) ram[k] <= ram_img[k];
        if (l2_req && l2_we) ram[l2_addr] <= l2_wdata;
        if (l2_req && !l2_we) l2_rdata <= ram[l2_addr];
    end

    // Expected post-invalidation state.
    logic [NS-1:0] m_l1_v;
    rab_l2_entry_t m_ram [L2N];
    int exp_l1, exp_l2;

    int n_checks = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // A config-register write answers SLVERR while the lock is held.
    function automatic logic [1:0] cfg_bresp(input logic locked);
        return locked ? 2'b10 : 2'b00;
    endfunction

    // Apply the overlap rules to the expected state; L2 limited to entries < k_lim.
    task automatic model_apply(input logic [AW-1:0] s, input logic [AW-1:0] e, input int k_lim);
        logic [VW-1:0] sp, ep;
        sp = s[AW-1:PB];
        ep = e[AW-1:PB];
        exp_l1 = 0;
        exp_l2 = 0;
        for (int i = 0; i < NS; i++) begin
            if (m_l1_v[i] && s <= e && l1_s[i] <= e && l1_e[i] >= s) begin
                m_l1_v[i] = 1'b0;
                exp_l1++;
            end
        end
        for (int k = 0; k < k_lim; k++) begin
            if (m_ram[k].valid && s <= e && m_ram[k].vpn >= sp && m_ram[k].vpn <= ep) begin
                m_ram[k].valid = 1'b0;
                exp_l2++;
            end
        end
    endtask

    task automatic load_all();
        @(posedge clk); #1;
        l1_ld_val = m_l1_v;
        l1_ld  = 1'b1;
        ram_ld = 1'b1;
        @(posedge clk); #1;
        l1_ld  = 1'b0;
        ram_ld = 1'b0;
    endtask

    task automatic set_l2(input int k, input int vpn, input logic v);
        ram_img[k].vpn   = VW'(vpn);
        ram_img[k].valid = v;
        m_ram[k]         = ram_img[k];
    endtask

    task automatic fill_contig();
        for (int i = 0; i < NS; i++) begin
            l1_s[i]   = AW'(i) << PB;
            l1_e[i]   = (AW'(i) << PB) + 32'hFFF;
            m_l1_v[i] = 1'b1;
        end
        for (int k = 0; k < L2N; k++) set_l2(k, NS + k, 1'b1);
    endtask

    task automatic clear_all();
        for (int i = 0; i < NS; i++) begin
            l1_s[i] = '0; l1_e[i] = '0; m_l1_v[i] = 1'b0;
        end
        for (int k = 0; k < L2N; k++) set_l2(k, 0, 1'b0);
    endtask

    // Per-request observations.
    int idle_waits, busy_n, lock_bad, l1_clr_n, multi_n, clr_window, overlap_n;
    int wr_n, bad_wr, done_n, first_clr_idx;
    logic [NS-1:0] first_clr_vec;
    logic [9:0]    last_wr_addr;
    logic [DW-1:0] last_wr_data;
    logic [1:0]    bresp_mid;
    logic          idle_lock;

    // Issue one request and follow it until the done pulse (bounded).
    task automatic run_req(input logic [AW-1:0] s, input logic [AW-1:0] e, input bit hold);
        int  n;
        bit  seen_done;
        busy_n = 0; lock_bad = 0; l1_clr_n = 0; multi_n = 0; clr_window = 0;
        overlap_n = 0; wr_n = 0; bad_wr = 0; done_n = -1; first_clr_idx = -1;
        first_clr_vec = '0; last_wr_addr = '0; last_wr_data = '0; bresp_mid = 2'b00;
        req_if.inval_start = s;
        req_if.inval_end   = e;
        req_if.inval_valid = 1'b1;
        idle_waits = 0;
        do begin
            @(negedge clk);
            idle_waits++;
        end while (!req_if.inval_ready && idle_waits < LAT + 100);
        idle_lock = lock;
        check_eq("accept_ready", req_if.inval_ready, 1);
        @(posedge clk); #1;
        if (!hold) req_if.inval_valid = 1'b0;
        req_if.inval_start = ~s;
        req_if.inval_end   = ~e;
        n = 0;
        seen_done = 1'b0;
        while (!seen_done && n < LAT + 100) begin
            @(negedge clk);
            n++;
            if (busy) busy_n++;
            if (lock != busy) lock_bad++;
            if (n == NS + 10) bresp_mid = cfg_bresp(lock);
            if (l1_clr != '0) begin
                l1_clr_n += $countones(l1_clr);
                if ($countones(l1_clr) > 1) multi_n++;
                if (n > NS) clr_window++;
                if (first_clr_idx < 0) begin
                    first_clr_idx = n - 1;
                    first_clr_vec = l1_clr;
                end
            end
            if (l2_req && (n <= NS || l1_clr != '0)) overlap_n++;
            if (l2_req && l2_we) begin
                wr_n++;
                last_wr_addr = l2_addr;
                last_wr_data = l2_wdata;
                if (l2_wdata[0] != 1'b0 || l2_wdata[DW-1:1] != ram_img[l2_addr].vpn) bad_wr++;
            end
            if (done) begin
                done_n = n;
                seen_done = 1'b1;
            end
        end
        check_eq("done_seen", seen_done, 1);
    endtask

    task automatic post_check(input logic [AW-1:0] s, input logic [AW-1:0] e);
        int d;
        d = 0;
        for (int k = 0; k < L2N; k++) if (ram[k] != m_ram[k]) d++;
        $display("req start=0x%08h end=0x%08h cnt=%0d exp=%0d l1=%0d l2=%0d done_at=%0d",
                 s, e, cnt, exp_l1 + exp_l2, l1_clr_n, wr_n, done_n);
        check_eq("done_latency", done_n, LAT);
        check_eq("busy_cycles", busy_n, LAT);
        check_eq("lock_eq_busy", lock_bad, 0);
        check_eq("cfg_wr_slverr", bresp_mid, 2'b10);
        check_eq("cnt", cnt, exp_l1 + exp_l2);
        check_eq("l1_clears", l1_clr_n, exp_l1);
        check_eq("l2_writes", wr_n, exp_l2);
        check_eq("clr_onehot", multi_n, 0);
        check_eq("clr_window", clr_window, 0);
        check_eq("l1_l2_overlap", overlap_n, 0);
        check_eq("wdata_form", bad_wr, 0);
        check_eq("l1_state", l1_v, m_l1_v);
        check_eq("l2_ram_diff", d, 0);
    endtask

    task automatic idle_check(input logic [15:0] exp_cnt);
        @(negedge clk);
        check_eq("idle_done_low", done, 0);
        check_eq("idle_ready", req_if.inval_ready, 1);
        check_eq("idle_lock", lock, 0);
        check_eq("cnt_hold", cnt, exp_cnt);
    endtask

    initial begin
        logic [AW-1:0] s, e, t;
        int  n;
        bit  found;

        req_if.inval_valid = 1'b0;
        req_if.inval_start = '0;
        req_if.inval_end   = '0;
        clear_all();
        l1_ld_val = '0;
        l1_ld  = 1'b1;
        ram_ld = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", req_if.inval_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_lock", lock, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_cnt", cnt, 0);
        check_eq("rst_l2_req", l2_req, 0);
        check_eq("rst_l1_clr", l1_clr, 0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        l1_ld  = 1'b0;
        ram_ld = 1'b0;

        // Everything contiguous from VA 0; one range covers it all.
        fill_contig();
        load_all();
        model_apply(32'h0, 32'h420FFF, L2N);
        run_req(32'h0, 32'h420FFF, 1'b0);
        post_check(32'h0, 32'h420FFF);
        check_eq("full_cnt", cnt, 1056);
        idle_check(16'd1056);

        // Single L2 entry vpn 1 at index 1.
        clear_all();
        set_l2(1, 1, 1'b1);
        load_all();
        model_apply(32'h1000, 32'h1FFF, L2N);
        run_req(32'h1000, 32'h1FFF, 1'b0);
        post_check(32'h1000, 32'h1FFF);
        check_eq("single_addr", last_wr_addr, 10'd1);
        check_eq("single_wdata", last_wr_data, {20'h1, 1'b0});
        check_eq("single_no_l1", l1_clr_n, 0);
        idle_check(16'd1);

        // Slice 5 boundary hit, then just-above-end miss.
        clear_all();
        l1_s[5] = 32'h400000; l1_e[5] = 32'h400FFF; m_l1_v[5] = 1'b1;
        load_all();
        model_apply(32'h400FFF, 32'h400FFF, L2N);
        run_req(32'h400FFF, 32'h400FFF, 1'b0);
        post_check(32'h400FFF, 32'h400FFF);
        check_eq("slice5_cycle", first_clr_idx, 5);
        check_eq("slice5_vec", first_clr_vec, 32'h1 << 5);
        m_l1_v[5] = 1'b1;
        load_all();
        model_apply(32'h401000, 32'h5FFFFF, L2N);
        run_req(32'h401000, 32'h5FFFFF, 1'b0);
        post_check(32'h401000, 32'h5FFFFF);
        check_eq("slice5_miss", l1_clr_n, 0);

        // Empty range over a fully populated table.
        fill_contig();
        load_all();
        model_apply(32'h2000, 32'h1000, L2N);
        run_req(32'h2000, 32'h1000, 1'b0);
        post_check(32'h2000, 32'h1000);
        check_eq("empty_cnt", cnt, 0);
        idle_check(16'd0);

        // Back-to-back with valid held across done: one-cycle gap in the lock.
        fill_contig();
        load_all();
        model_apply(32'h0, 32'h7FFF, L2N);
        run_req(32'h0, 32'h7FFF, 1'b1);
        post_check(32'h0, 32'h7FFF);
        model_apply(32'h20000, 32'h30FFF, L2N);
        run_req(32'h20000, 32'h30FFF, 1'b0);
        check_eq("b2b_idle_cycles", idle_waits, 1);
        check_eq("b2b_idle_lock", idle_lock, 0);
        post_check(32'h20000, 32'h30FFF);

        // Randomised slices, RAM contents and ranges (some empty).
        for (int it = 0; it < 5; it++) begin
            for (int i = 0; i < NS; i++) begin
                l1_s[i]   = AW'($urandom_range(0, 63)) << PB;
                l1_e[i]   = l1_s[i] + (AW'($urandom_range(0, 3)) << PB) + 32'hFFF;
                m_l1_v[i] = 1'($urandom_range(0, 1));
            end
            for (int k = 0; k < L2N; k++) set_l2(k, int'($urandom_range(0, 79)), 1'($urandom_range(0, 1)));
            load_all();
            s = AW'($urandom_range(0, 32'h50000));
            e = s + AW'($urandom_range(0, 32'h10000));
            if ($urandom_range(0, 4) == 0) begin
                t = s; s = e; e = t;
            end
            model_apply(s, e, L2N);
            run_req(s, e, 1'b0);
            post_check(s, e);
        end

        // Reset while the L2 walk is reading entry 100.
        fill_contig();
        load_all();
        model_apply(32'h0, 32'h420FFF, 100);
        req_if.inval_start = 32'h0;
        req_if.inval_end   = 32'h420FFF;
        req_if.inval_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_if.inval_ready && n < 100);
        @(posedge clk); #1;
        req_if.inval_valid = 1'b0;
        found = 1'b0;
        n = 0;
        while (!found && n < LAT + 100) begin
            @(negedge clk);
            n++;
            if (l2_req && !l2_we && l2_addr == 10'd100) found = 1'b1;
        end
        check_eq("rst_reach_k100", found, 1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_ready", req_if.inval_ready, 1);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_cnt", cnt, 0);
        check_eq("midrst_l2_req", l2_req, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        wr_n = 0;
        done_n = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (l2_req && l2_we) wr_n++;
            if (done) done_n++;
        end
        check_eq("midrst_no_writes", wr_n, 0);
        check_eq("midrst_no_done", done_n, 0);
        check_eq("midrst_ready_after", req_if.inval_ready, 1);
        check_eq("midrst_cnt_after", cnt, 0);
        begin
            int d;
            d = 0;
            for (int k = 0; k < L2N; k++) if (ram[k] != m_ram[k]) d++;
            check_eq("midrst_l2_ram_diff", d, 0);
        end
        check_eq("midrst_l1_state", l1_v, m_l1_v);
        $display("req start=0x%08h end=0x%08h reset at k=100", 32'h0, 32'h420FFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/rab_inval_sequencer.md
# rab_inval_sequencer

Invalidation controller for the remapping address block (RAB). It accepts one virtual-address range from the configuration port's invalidate registers (start at offset 0x10, end at 0x18, triggered by the end write). It then walks every L1 slice and every L2 TLB entry and clears the valid bit of each entry whose page range overlaps the request. While it runs, it holds the config lock, so concurrent L1/L2 config writes are answered with SLVERR. It sits between the config register file and the L1 slice flops / L2 TLB RAM of the accelerator-side port.

## Interface
- AW, 32, virtual/physical address width
- N_SLICES, 32, total L1 slices (host + accelerator ports)
- L2_N_SETS, 32, L2 TLB sets
- L2_N_SET_ENTRIES, 32, entries per set; L2_N = L2_N_SETS*L2_N_SET_ENTRIES
- PAGE_BITS, 12, log2 page size
- clk_i  in  1  clock; all logic on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- inval_valid_i  in  1  request valid
- inval_ready_o  out  1  high only in IDLE
- inval_start_i  in  AW  inclusive range start
- inval_end_i  in  AW  inclusive range end
- l1_start_i  in  N_SLICES×AW  slice VA start
- l1_end_i  in  N_SLICES×AW  slice VA end
- l1_valid_i  in  N_SLICES  slice valid bit (prot bit 0)
- l1_clr_o  out  N_SLICES  one-hot pulse: clear slice prot bits
- l2_req_o  out  1  RAM access enable
- l2_we_o  out  1  write (1) / read (0)
- l2_addr_o  out  log2(L2_N)  entry index = set*L2_N_SET_ENTRIES+entry
- l2_wdata_o  out  AW-PAGE_BITS+1  {vpn, valid}; write carries valid=0
- l2_rdata_i  in  AW-PAGE_BITS+1  {vpn, valid}; valid one cycle after read
- cfg_lock_o  out  1  config-write lock
- busy_o  out  1  not IDLE
- inval_done_o  out  1  one-cycle completion pulse
- inval_cnt_o  out  16  entries cleared by last request; saturates at 0xFFFF

## Operation
- States: IDLE, L1_SCAN, L2_RD, L2_CHK, DONE.
- IDLE: on valid&&ready, register start/end, clear the counter and index, go to L1_SCAN.
- L1_SCAN, index i = 0..N_SLICES-1, one slice per cycle:
  - Hit = l1_valid_i[i] && l1_start_i[i] <= end && l1_end_i[i] >= start.
  - On hit, l1_clr_o[i] = 1 in that cycle and the counter increments.
  - After i = N_SLICES-1, go to L2_RD with k = 0.
- L2_RD: l2_req_o = 1, we = 0, addr = k; go to L2_CHK.
- L2_CHK:
  - Hit = valid && vpn >= start>>PAGE_BITS && vpn <= end>>PAGE_BITS.
  - On hit: l2_req_o = 1, we = 1, addr = k, wdata = {vpn, 0}, counter increments.
  - If k = L2_N-1, go to DONE; otherwise k+1 and go to L2_RD.
- DONE: inval_done_o = 1, then IDLE.
- Empty range (start > end): no hits; all entries are still walked and done still pulses.
- Comparisons are unsigned, full AW width; no wrap-around.

## Timing
- Reset values: state IDLE; inval_ready_o = 1; every other output 0; inval_cnt_o = 0.
- Outputs are registered-state decodes and are never combinational from inval_valid_i.
- Latency: accept edge to done pulse = N_SLICES + 2·L2_N + 1 cycles. For the defaults that is 32 + 2048 + 1 = 2081.
- cfg_lock_o = busy_o; it rises the cycle after accept and falls with done.
- Inputs start/end are sampled only at accept; later changes are ignored.
- Requests while busy are not accepted; ready is low and inval_valid_i must be held.
- inval_cnt_o holds until the next accept.
- Reset mid-operation: immediately IDLE, no further clears, no done pulse. Entries already cleared stay cleared.
- No simultaneous L1 and L2 activity. At most one l1_clr_o bit is active per cycle.

## Structure
- rab_inval_pkg holds:
  - the state enum (rab_inval_state_e);
  - the L2 entry struct (rab_l2_entry_t: vpn, valid);
  - the function clog2 width constant for L2 index.
- Sub-module rab_inval_range_cmp: combinational inclusive-range overlap check on AW-wide inputs. Instantiated twice, once for L1 (address) and once for L2 (VPN, page-shifted).
- Single FSM plus index counter in the top; no FIFO.

## Test plan
- Reset during L2 walk (k = 100) -> ready = 1 next cycle, no further l2_we_o, inval_done_o never pulses, cnt = 0.
- Fill all 32 slices and 1024 L2 entries contiguously from VA 0; request [0, 0x420FFF] -> every slice and every L2 entry cleared, cnt = 1056, done 2081 cycles after accept.
- Request [0x1000, 0x1FFF] with L2 entry vpn 0x1 at index 1 only -> exactly one L2 write (addr 1, wdata {0x1, 0}), no l1_clr_o, cnt = 1.
- Slice 5 = [0x400000, 0x400FFF]; request [0x400FFF, 0x400FFF] -> l1_clr_o = 1<<5 in L1_SCAN cycle 5; request [0x401000, 0x5FFFFF] -> no clear.
- start = 0x2000, end = 0x1000 -> no clears, done still pulses, cnt = 0.
- inval_valid_i held high across done -> second request is accepted in the IDLE cycle after done. cfg_lock_o is low for exactly that one cycle, and config writes during busy return SLVERR.
